spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: SYNC_STAGES, 2, flops per synchronizer on sck_in/ss_in/mosi_in; legal 2..3.
REQ-002 clk_in  input  1  system clock; one clock domain; must run >= 4x SCK frequency.
REQ-003 rstn_in  input  1  reset, asynchronous, active-low.
REQ-004 spe_in  input  1  slave enable; low = block disabled.
REQ-005 cpol_in, cpha_in, lsbfe_in  input  1 each  clock polarity, clock phase, LSB-first select; sampled only in IDLE.
REQ-006 tx_data_in  input  8  next byte to send.
REQ-007 tx_load_in  input  1  one-cycle pulse; writes tx_data_in into tx buffer.
REQ-008 tx_empty_out  output  1  tx buffer empty.
REQ-009 rx_data_out  output  8  last received byte.
REQ-010 rx_full_out  output  1  rx_data_out holds an unread byte.
REQ-011 rx_read_in  input  1  one-cycle pulse; clears rx_full_out.
REQ-012 overrun_out  output  1  sticky: byte completed while rx_full_out high.
REQ-013 busy_out  output  1  high in SHIFT state.
REQ-014 sck_in, ss_in, mosi_in  input  1 each  SPI pins from master; ss_in active-low.
REQ-015 miso_out  output  1  serial data to master.
REQ-016 miso_oe_out  output  1  miso driver enable; high only while selected and enabled.

Function
REQ-017 sck_in, ss_in, mosi_in SHALL each pass through SYNC_STAGES flops before any use; edges SHALL be detected by comparing consecutive synchronized samples.
REQ-018 States: DISABLE, IDLE, SHIFT, DONE; spe_in low from any state -> DISABLE next cycle.
REQ-019 DISABLE -> IDLE when spe_in high; in DISABLE rx_full_out, overrun_out, bit counter SHALL clear and tx buffer SHALL be marked empty.
REQ-020 IDLE -> SHIFT on synchronized ss falling edge; on that cycle tx buffer SHALL copy to shift register and tx_empty_out SHALL set; if tx buffer empty, shift register loads 0xFF.
REQ-021 Leading edge = SCK transition away from cpol_in level; trailing edge = return to it.
REQ-022 cpha_in=0: first bit on miso_out from SHIFT entry; sample mosi on leading edge; shift out next bit on trailing edge.
REQ-023 cpha_in=1: shift out bit on leading edge (first leading edge drives bit 0 of sequence); sample on trailing edge.
REQ-024 Bit order: lsbfe_in=0 MSB first, lsbfe_in=1 LSB first, for both directions.
REQ-025 4-bit counter SHALL count sample edges; 8th sample edge -> DONE.
REQ-026 DONE (one cycle): if rx_full_out low, rx_data_out <= received byte and rx_full_out sets; else rx_data_out unchanged and overrun_out sets; then -> SHIFT with next tx byte loaded per REQ-020 if ss still low, else IDLE.
REQ-027 ss rising edge in SHIFT before 8th sample edge SHALL abort: counter cleared, no rx update, no flag change, -> IDLE.
REQ-028 rx_read_in and DONE completion in the same cycle: read clears first, new byte stored, rx_full_out stays high, no overrun.
REQ-029 tx_load_in while tx_empty_out low SHALL overwrite the buffer; tx_load_in coincident with REQ-020 load: old buffer content shifts, new data stays in buffer, tx_empty_out low.
REQ-030 miso_oe_out = spe_in high AND synchronized ss low AND state SHIFT/DONE; miso_out SHALL be 0 when miso_oe_out low.
REQ-031 Latency: rx_full_out rises SYNC_STAGES+2 clk_in cycles after the 8th physical sample edge.
REQ-032 overrun_out SHALL clear only on reset or DISABLE.

Reset
REQ-033 On rstn_in low, asynchronously: state DISABLE, rx_data_out 0x00, rx_full_out 0, overrun_out 0, tx_empty_out 1, busy_out 0, miso_out 0, miso_oe_out 0, synchronizers to idle levels (ss 1, sck 0, mosi 0).
REQ-034 Reset mid-transfer SHALL discard partial byte; after release, block waits for a fresh ss falling edge.

Verification
REQ-035 Mode 0 MSB-first: load 0xA5, master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data_out 0x3C, rx_full_out 1.
REQ-036 Mode 3 LSB-first: load 0x81, master sends 0x01 -> master receives 0x81; rx_data_out 0x01.
REQ-037 Two bytes 0x11, 0x22 with no rx_read_in -> rx_data_out 0x11, overrun_out 1.
REQ-038 ss raised after 5 bits -> rx_full_out stays 0, busy_out 0, next full byte 0x5A received correctly.
REQ-039 No tx_load_in before transfer -> master receives 0xFF; tx_empty_out stays 1.
REQ-040 spe_in low mid-byte then high -> overrun_out 0, rx_full_out 0, miso_oe_out 0 until next ss falling edge.

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave, modes 0-3, MSB/LSB first, single-byte tx/rx buffers with overrun flag.
// Latency: rx_full_out rises SYNC_STAGES+2 clk_in cycles after the 8th sample edge; no backpressure.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       rstn_in,
  input  logic       spe_in,
  input  logic       cpol_in,
  input  logic       cpha_in,
  input  logic       lsbfe_in,
  input  logic [7:0] tx_data_in,
  input  logic       tx_load_in,
  output logic       tx_empty_out,
  output logic [7:0] rx_data_out,
  output logic       rx_full_out,
  input  logic       rx_read_in,
  output logic       overrun_out,
  output logic       busy_out,
  input  logic       sck_in,
  input  logic       ss_in,
  input  logic       mosi_in,
  output logic       miso_out,
  output logic       miso_oe_out
);

  typedef enum logic [1:0] {ST_DISABLE, ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sck_prev_q, ss_prev_q;
  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [7:0]             tx_buf_q, tx_buf_d, tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
  logic                   tx_empty_q, tx_empty_d, rx_full_q, rx_full_d, ovr_q, ovr_d;
  logic                   cpol_q, cpol_d, cpha_q, cpha_d, lsbfe_q, lsbfe_d, armed_q, armed_d;
  logic                   sck_s, ss_s, mosi_s, sck_chg, lead_edge, trail_edge;
  logic                   sample_edge, shift_edge, ss_fall, ss_rise, load_sr;

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_in};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_in};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
    end
  end

  assign sck_s       = sck_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sck_chg     = sck_s ^ sck_prev_q;
  assign lead_edge   = sck_chg & (sck_s != cpol_q);
  assign trail_edge  = sck_chg & (sck_s == cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;
  assign ss_fall     = ss_prev_q & ~ss_s;
  assign ss_rise     = ~ss_prev_q & ss_s;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_buf_d   = tx_buf_q;
    tx_empty_d = tx_empty_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_full_d  = rx_full_q;
    ovr_d      = ovr_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsbfe_d    = lsbfe_q;
    armed_d    = 1'b0;
    load_sr    = 1'b0;
    if (rx_read_in) rx_full_d = 1'b0;
    if (tx_load_in) begin
      tx_buf_d   = tx_data_in;
      tx_empty_d = 1'b0;
    end
    case (state_q)
      ST_DISABLE: begin
        rx_full_d  = 1'b0;
        ovr_d      = 1'b0;
        cnt_d      = 4'd0;
        tx_empty_d = 1'b1;
        if (spe_in) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        cpol_d  = cpol_in;
        cpha_d  = cpha_in;
        lsbfe_d = lsbfe_in;
        // Only a falling edge after ss has been seen settled high starts a frame,
        // so a stale synchronizer after reset/enable cannot fake one.
        armed_d = armed_q | ((&ss_sync_q) & ss_prev_q);
        if (armed_q && ss_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = 4'd0;
          load_sr = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          // The first shift-edge of a byte (count still 0) keeps bit 0 on the line.
          if (shift_edge && cnt_q != 4'd0)
            tx_sr_d = lsbfe_q ? {1'b0, tx_sr_q[7:1]} : {tx_sr_q[6:0], 1'b0};
          if (sample_edge) begin
            rx_sr_d = lsbfe_q ? {mosi_s, rx_sr_q[7:1]} : {rx_sr_q[6:0], mosi_s};
            if (cnt_q == 4'd7) begin
              cnt_d   = 4'd0;
              state_d = ST_DONE;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
      end
      ST_DONE: begin
        if (rx_full_q && !rx_read_in) begin
          ovr_d = 1'b1;
        end else begin
          rx_data_d = rx_sr_q;
          rx_full_d = 1'b1;
        end
        if (!ss_s) begin
          state_d = ST_SHIFT;
          load_sr = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_DISABLE;
    endcase
    if (load_sr) begin
      tx_sr_d = tx_empty_q ? 8'hFF : tx_buf_q;
      if (!tx_load_in) tx_empty_d = 1'b1;
    end
    if (!spe_in) state_d = ST_DISABLE;
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q    <= ST_DISABLE;
      cnt_q      <= 4'd0;
      tx_buf_q   <= 8'h00;
      tx_empty_q <= 1'b1;
      tx_sr_q    <= 8'h00;
      rx_sr_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_full_q  <= 1'b0;
      ovr_q      <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsbfe_q    <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_buf_q   <= tx_buf_d;
      tx_empty_q <= tx_empty_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_full_q  <= rx_full_d;
      ovr_q      <= ovr_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsbfe_q    <= lsbfe_d;
      armed_q    <= armed_d;
    end
  end

  assign miso_oe_out  = spe_in & ~ss_s & ((state_q == ST_SHIFT) | (state_q == ST_DONE));
  assign miso_out     = miso_oe_out & (lsbfe_q ? tx_sr_q[0] : tx_sr_q[7]);
  assign busy_out     = (state_q == ST_SHIFT);
  assign tx_empty_out = tx_empty_q;
  assign rx_data_out  = rx_data_q;
  assign rx_full_out  = rx_full_q;
  assign overrun_out  = ovr_q;

endmodule

// File: tb/tb_spi_slave.sv
// Randomized SPI master driving spi_slave; scoreboard queues checked by rx and miso monitors.
module tb_spi_slave;
  localparam time H = 60;

  logic       clk_in = 1'b0, rstn_in = 1'b0, spe_in = 1'b0;
  logic       cpol_in = 1'b0, cpha_in = 1'b0, lsbfe_in = 1'b0;
  logic [7:0] tx_data_in = 8'h00;
  logic       tx_load_in = 1'b0, rx_read_in = 1'b0;
  logic       sck_in = 1'b0, ss_in = 1'b1, mosi_in = 1'b0;
  logic       tx_empty_out, rx_full_out, overrun_out, busy_out, miso_out, miso_oe_out;
  logic [7:0] rx_data_out;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk_in(clk_in), .rstn_in(rstn_in), .spe_in(spe_in),
    .cpol_in(cpol_in), .cpha_in(cpha_in), .lsbfe_in(lsbfe_in),
    .tx_data_in(tx_data_in), .tx_load_in(tx_load_in), .tx_empty_out(tx_empty_out),
    .rx_data_out(rx_data_out), .rx_full_out(rx_full_out), .rx_read_in(rx_read_in),
    .overrun_out(overrun_out), .busy_out(busy_out),
    .sck_in(sck_in), .ss_in(ss_in), .mosi_in(mosi_in),
    .miso_out(miso_out), .miso_oe_out(miso_oe_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0, bad = 0;
  logic [7:0] exp_rx_q[$], exp_miso_q[$];
  // Reference model: buffer/flag state as seen from outside the slave.
  bit         mdl_full = 0, mdl_ovr = 0, tx_pend = 0;
  logic [7:0] tx_val = 8'h00, cur_tx = 8'hFF, last_rx = 8'h00;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // rx monitor: each new byte shows up as a rising rx_full_out.
  logic prev_full = 1'b0;
  always @(negedge clk_in) begin
    if (rx_full_out && !prev_full) begin
      check("rx_expected", exp_rx_q.size() > 0, 1);
      if (exp_rx_q.size() > 0) check("rx_data", rx_data_out, exp_rx_q.pop_front());
    end
    prev_full = rx_full_out;
  end

  // miso monitor: master-side capture at each sample edge of the current mode.
  int         mcnt = 0;
  logic [7:0] mbyte = 8'h00;
  always @(posedge ss_in) mcnt = 0;
  always @(sck_in) begin
    if (!ss_in && ((sck_in != cpol_in) == !cpha_in)) begin
      if (lsbfe_in) mbyte[mcnt] = miso_out;
      else          mbyte[7-mcnt] = miso_out;
      mcnt++;
      if (mcnt == 8) begin
        mcnt = 0;
        check("miso_expected", exp_miso_q.size() > 0, 1);
        if (exp_miso_q.size() > 0) check("miso_byte", mbyte, exp_miso_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #2;
  endtask

  task automatic pulse_load(input logic [7:0] d);
    tx_data_in = d; tx_load_in = 1'b1; tick(1); tx_load_in = 1'b0;
    tx_pend = 1; tx_val = d;
  endtask

  task automatic pulse_read();
    rx_read_in = 1'b1; tick(1); rx_read_in = 1'b0;
    mdl_full = 0;
  endtask

  task automatic set_mode(input logic c, input logic p, input logic l);
    cpol_in = c; cpha_in = p; lsbfe_in = l; sck_in = c;
    tick(8);
  endtask

  task automatic frame_start();
    cur_tx  = tx_pend ? tx_val : 8'hFF;
    tx_pend = 0;
    ss_in   = 1'b0;
    tick(8);
  endtask

  task automatic frame_end();
    #H; ss_in = 1'b1;
    tick(10);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits);
    logic b;
    if (nbits == 8) begin
      exp_miso_q.push_back(cur_tx);
      cur_tx = 8'hFF;
      if (mdl_full) mdl_ovr = 1;
      else begin exp_rx_q.push_back(mo); mdl_full = 1; last_rx = mo; end
    end
    for (int i = 0; i < nbits; i++) begin
      b = lsbfe_in ? mo[i] : mo[7-i];
      if (!cpha_in) begin
        mosi_in = b; #H; sck_in = ~cpol_in; #H; sck_in = cpol_in;
      end else begin
        sck_in = ~cpol_in; mosi_in = b; #H; sck_in = cpol_in; #H;
      end
    end
  endtask

  task automatic model_disable();
    mdl_full = 0; mdl_ovr = 0; tx_pend = 0;
  endtask

  initial begin
    tick(3);
    check("rst_rx_data", rx_data_out, 8'h00);
    check("rst_rx_full", rx_full_out, 0);
    check("rst_overrun", overrun_out, 0);
    check("rst_tx_empty", tx_empty_out, 1);
    check("rst_busy", busy_out, 0);
    check("rst_miso", miso_out, 0);
    check("rst_miso_oe", miso_oe_out, 0);
    rstn_in = 1'b1; spe_in = 1'b1;
    set_mode(0, 0, 0);

    // mode 0 MSB first
    pulse_load(8'hA5);
    check("tx_empty_loaded", tx_empty_out, 0);
    frame_start();
    check("busy_in_frame", busy_out, 1);
    check("oe_in_frame", miso_oe_out, 1);
    check("tx_empty_consumed", tx_empty_out, 1);
    xfer(8'h3C, 8);
    frame_end();
    check("rx_full_m0", rx_full_out, mdl_full);
    check("rx_data_m0", rx_data_out, 8'h3C);
    pulse_read();
    check("rx_full_read", rx_full_out, mdl_full);

    // mode 3 LSB first
    set_mode(1, 1, 1);
    pulse_load(8'h81);
    frame_start(); xfer(8'h01, 8); frame_end();
    check("rx_data_m3", rx_data_out, 8'h01);
    pulse_read();

    // two bytes without read -> overrun, first byte kept
    set_mode(0, 0, 0);
    frame_start(); xfer(8'h11, 8); frame_end();
    frame_start(); xfer(8'h22, 8); frame_end();
    check("ovr_set", overrun_out, mdl_ovr);
    check("ovr_keep_data", rx_data_out, last_rx);
    pulse_read();
    check("ovr_sticky", overrun_out, mdl_ovr);

    // disable mid-byte clears flags, slave stays off the line
    frame_start(); xfer(8'hC3, 4);
    spe_in = 1'b0; tick(3); spe_in = 1'b1; tick(4);
    model_disable();
    check("spe_ovr", overrun_out, mdl_ovr);
    check("spe_rx_full", rx_full_out, mdl_full);
    check("spe_oe", miso_oe_out, 0);
    frame_end();

    // abort after 5 bits, then a clean byte
    frame_start(); xfer(8'hF0, 5); frame_end();
    check("abort_rx_full", rx_full_out, 0);
    check("abort_busy", busy_out, 0);
    frame_start(); xfer(8'h5A, 8); frame_end();
    check("after_abort_data", rx_data_out, 8'h5A);
    check("no_load_tx_empty", tx_empty_out, 1);
    pulse_read();

    // reset mid-frame: partial byte dropped, needs a fresh ss fall
    pulse_load(8'h77);
    frame_start(); xfer(8'h99, 3);
    rstn_in = 1'b0; tick(2); rstn_in = 1'b1; tick(6);
    model_disable();
    check("rstmid_busy", busy_out, 0);
    check("rstmid_rx_full", rx_full_out, 0);
    check("rstmid_tx_empty", tx_empty_out, 1);
    frame_end();

    for (int it = 0; it < 30; it++) begin
      int nb;
      if ($urandom_range(0, 5) == 0) begin
        spe_in = 1'b0; tick(3); spe_in = 1'b1; tick(3);
        model_disable();
      end
      set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) pulse_load(8'($urandom));
      if (mdl_full && $urandom_range(0, 2) != 0) pulse_read();
      nb = $urandom_range(1, 2);
      frame_start();
      for (int k = 0; k < nb; k++) xfer(8'($urandom), 8);
      frame_end();
      check("rnd_ovr", overrun_out, mdl_ovr);
      check("rnd_rx_full", rx_full_out, mdl_full);
    end

    tick(20);
    check("rx_q_left", exp_rx_q.size(), 0);
    check("miso_q_left", exp_miso_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
